// File: rtl/select_encode_reg.sv
// -----------------------------------------------------------------------------
// select_encode_reg
//
// Register select/encode unit sitting between the control unit and the
// general-purpose register file / bus mux. It keeps a private copy of the
// instruction register, decodes the Ra/Rb/Rc fields into a registered one-hot
// selection (with a validity flag), and gates that selection with the
// Rin/Rout/BAout strobes to produce per-register write/read enables.
// R0 used as a base address reads as zero on the bus, so BAout on R0 raises
// BA_zero instead of a read enable. The C immediate is sign-extended here too.
//
// Ports:
//   clock            system clock, rising edge
//   clear            asynchronous active-high reset
//   IRin             load instruction_in into the internal IR
//   instruction_in   instruction word from the bus
//   Gra/Grb/Grc      select Ra/Rb/Rc field (priority Gra > Grb > Grc)
//   Rin/Rout/BAout   write / read / base-address read strobes
//   R_in, R_out      one-hot register write / read enables
//   BA_zero          bus mux must drive zero (BAout on R0 without Rout)
//   C_sign_extended  sign-extended C immediate from the IR
//   sel_valid        a selection is latched and current
//   sel_error        sticky: more than one G line asserted in one cycle
//   ir_q             current IR contents
// -----------------------------------------------------------------------------
module select_encode_reg #(
  parameter int NUM_REGS   = 16,
  parameter int REG_BITS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RA_MSB     = 26,
  parameter int IMM_WIDTH  = 19
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  IRin,
  input  logic [DATA_WIDTH-1:0] instruction_in,
  input  logic                  Gra,
  input  logic                  Grb,
  input  logic                  Grc,
  input  logic                  Rin,
  input  logic                  Rout,
  input  logic                  BAout,
  output logic [NUM_REGS-1:0]   R_in,
  output logic [NUM_REGS-1:0]   R_out,
  output logic                  BA_zero,
  output logic [DATA_WIDTH-1:0] C_sign_extended,
  output logic                  sel_valid,
  output logic                  sel_error,
  output logic [DATA_WIDTH-1:0] ir_q
);

  localparam int RB_MSB = RA_MSB - REG_BITS;
  localparam int RC_MSB = RB_MSB - REG_BITS;

  logic [DATA_WIDTH-1:0] ir_d;
  logic [NUM_REGS-1:0]   sel_q;
  logic [NUM_REGS-1:0]   sel_d;
  logic                  sel_valid_q;
  logic                  sel_valid_d;
  logic                  sel_error_q;
  logic                  sel_error_d;

  logic [REG_BITS-1:0]   ra_s;
  logic [REG_BITS-1:0]   rb_s;
  logic [REG_BITS-1:0]   rc_s;
  logic [REG_BITS-1:0]   field_s;
  logic                  g_any_s;
  logic                  g_conflict_s;
  logic [NUM_REGS-1:0]   ba_mask_s;

  // Fields always come from the held IR, never from the bus.
  assign ra_s = ir_q[RA_MSB -: REG_BITS];
  assign rb_s = ir_q[RB_MSB -: REG_BITS];
  assign rc_s = ir_q[RC_MSB -: REG_BITS];

  assign g_any_s      = Gra | Grb | Grc;
  assign g_conflict_s = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);

  // IR next state: load on IRin, otherwise hold.
  always_comb begin
    ir_d = ir_q;
    if (IRin) begin
      ir_d = instruction_in;
    end else begin
      ir_d = ir_q;
    end
  end

  // Selection next state. IRin wins over G so a selection is never decoded
  // from the IR that is about to be replaced; no G means hold, letting the
  // control unit pulse G once and strobe Rin/Rout for several cycles.
  always_comb begin
    field_s     = rc_s;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    sel_error_d = sel_error_q;
    if (Gra) begin
      field_s = ra_s;
    end else if (Grb) begin
      field_s = rb_s;
    end else begin
      field_s = rc_s;
    end
    if (IRin) begin
      sel_d       = {NUM_REGS{1'b0}};
      sel_valid_d = 1'b0;
    end else if (g_any_s) begin
      sel_d       = {{(NUM_REGS-1){1'b0}}, 1'b1} << field_s;
      sel_valid_d = 1'b1;
      sel_error_d = sel_error_q | g_conflict_s;
    end else begin
      sel_d       = sel_q;
      sel_valid_d = sel_valid_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      ir_q        <= {DATA_WIDTH{1'b0}};
      sel_q       <= {NUM_REGS{1'b0}};
      sel_valid_q <= 1'b0;
      sel_error_q <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      sel_error_q <= sel_error_d;
    end
  end

  // BAout reads every register except R0; R0 as a base means literal zero.
  assign ba_mask_s = {{(NUM_REGS-1){BAout}}, 1'b0};

  assign R_in    = sel_q & {NUM_REGS{sel_valid_q & Rin}};
  assign R_out   = sel_q & {NUM_REGS{sel_valid_q}} & ({NUM_REGS{Rout}} | ba_mask_s);
  assign BA_zero = sel_q[0] & sel_valid_q & BAout & ~Rout;

  assign C_sign_extended = {{(DATA_WIDTH-IMM_WIDTH){ir_q[IMM_WIDTH-1]}}, ir_q[IMM_WIDTH-1:0]};

  assign sel_valid = sel_valid_q;
  assign sel_error = sel_error_q;

endmodule

// File: tb/tb_select_encode_reg.sv
module tb_select_encode_reg;

  localparam logic L0 = 1'b0;
  localparam logic L1 = 1'b1;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        IRin = 1'b0, Gra = 1'b0, Grb = 1'b0, Grc = 1'b0;
  logic        Rin = 1'b0, Rout = 1'b0, BAout = 1'b0;
  logic [31:0] instruction_in = 32'h0;
  logic [15:0] R_in, R_out;
  logic        BA_zero, sel_valid, sel_error;
  logic [31:0] C_sign_extended, ir_q;

  // second instance: 32 registers, 5-bit fields
  logic        IRin2 = 1'b0, Gra2 = 1'b0, Rin2 = 1'b0, Rout2 = 1'b0;
  logic [31:0] instruction_in2 = 32'h0;
  logic [31:0] R_in2, R_out2, C_sign_extended2, ir_q2;
  logic        BA_zero2, sel_valid2, sel_error2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  select_encode_reg dut (
    .clock(clock), .clear(clear), .IRin(IRin), .instruction_in(instruction_in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .R_in(R_in), .R_out(R_out), .BA_zero(BA_zero), .C_sign_extended(C_sign_extended),
    .sel_valid(sel_valid), .sel_error(sel_error), .ir_q(ir_q)
  );

  select_encode_reg #(.NUM_REGS(32), .REG_BITS(5), .RA_MSB(26)) dut2 (
    .clock(clock), .clear(clear), .IRin(IRin2), .instruction_in(instruction_in2),
    .Gra(Gra2), .Grb(1'b0), .Grc(1'b0), .Rin(Rin2), .Rout(Rout2), .BAout(1'b0),
    .R_in(R_in2), .R_out(R_out2), .BA_zero(BA_zero2), .C_sign_extended(C_sign_extended2),
    .sel_valid(sel_valid2), .sel_error(sel_error2), .ir_q(ir_q2)
  );

  typedef struct {
    logic        irin;
    logic [31:0] instr;
    logic        gra, grb, grc, rin, rout, baout;
    logic [15:0] e_rin, e_rout;
    logic        e_baz, e_valid, e_err;
    logic [31:0] e_ir, e_csx;
  } vec_t;

  vec_t vecs[21];
  vec_t sb_q[$];

  function automatic vec_t mk(input logic irin, input logic [31:0] instr,
                              input logic gra, input logic grb, input logic grc,
                              input logic rin, input logic rout, input logic baout,
                              input logic [15:0] e_rin, input logic [15:0] e_rout,
                              input logic e_baz, input logic e_valid, input logic e_err,
                              input logic [31:0] e_ir, input logic [31:0] e_csx);
    vec_t v;
    v.irin = irin; v.instr = instr; v.gra = gra; v.grb = grb; v.grc = grc;
    v.rin = rin; v.rout = rout; v.baout = baout;
    v.e_rin = e_rin; v.e_rout = e_rout; v.e_baz = e_baz; v.e_valid = e_valid;
    v.e_err = e_err; v.e_ir = e_ir; v.e_csx = e_csx;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: expected outputs for the cycle just driven, compared mid-cycle
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      vec_t e;
      e = sb_q.pop_front();
      chk("R_in", {16'h0, R_in}, {16'h0, e.e_rin});
      chk("R_out", {16'h0, R_out}, {16'h0, e.e_rout});
      chk("BA_zero", {31'h0, BA_zero}, {31'h0, e.e_baz});
      chk("sel_valid", {31'h0, sel_valid}, {31'h0, e.e_valid});
      chk("sel_error", {31'h0, sel_error}, {31'h0, e.e_err});
      chk("ir_q", ir_q, e.e_ir);
      chk("C_sign_extended", C_sign_extended, e.e_csx);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // IR=0A9A0000: Ra=5 Rb=3 Rc=4 imm=0x20000
    // IR=00308000: Ra=0 Rb=6 Rc=1 imm=0x08000
    // IR=01048000: Ra=2 Rb=0 Rc=9 imm=0x48000 (negative)
    // IR=0007FFFF: imm=0x7FFFF (all ones)
    vecs[0]  = mk(L1, 32'h0A9A0000, L0,L0,L0, L0,L0,L0, 16'h0000,16'h0000, L0,L0,L0, 32'h00000000,32'h00000000);
    vecs[1]  = mk(L0, 32'h0,        L0,L1,L0, L0,L0,L0, 16'h0000,16'h0000, L0,L0,L0, 32'h0A9A0000,32'h00020000);
    vecs[2]  = mk(L0, 32'h0,        L0,L0,L0, L0,L1,L0, 16'h0000,16'h0008, L0,L1,L0, 32'h0A9A0000,32'h00020000);
    vecs[3]  = mk(L0, 32'h0,        L1,L0,L0, L0,L0,L0, 16'h0000,16'h0000, L0,L1,L0, 32'h0A9A0000,32'h00020000);
    vecs[4]  = mk(L0, 32'h0,        L0,L0,L0, L1,L0,L0, 16'h0020,16'h0000, L0,L1,L0, 32'h0A9A0000,32'h00020000);
    vecs[5]  = mk(L0, 32'h0,        L0,L0,L0, L1,L0,L0, 16'h0020,16'h0000, L0,L1,L0, 32'h0A9A0000,32'h00020000);
    vecs[6]  = mk(L0, 32'h0,        L0,L0,L0, L1,L0,L0, 16'h0020,16'h0000, L0,L1,L0, 32'h0A9A0000,32'h00020000);
    vecs[7]  = mk(L1, 32'h00308000, L0,L0,L0, L0,L0,L0, 16'h0000,16'h0000, L0,L1,L0, 32'h0A9A0000,32'h00020000);
    vecs[8]  = mk(L0, 32'h0,        L1,L0,L0, L0,L0,L0, 16'h0000,16'h0000, L0,L0,L0, 32'h00308000,32'h00008000);
    vecs[9]  = mk(L0, 32'h0,        L0,L0,L0, L0,L0,L1, 16'h0000,16'h0000, L1,L1,L0, 32'h00308000,32'h00008000);
    vecs[10] = mk(L0, 32'h0,        L0,L0,L0, L0,L1,L1, 16'h0000,16'h0001, L0,L1,L0, 32'h00308000,32'h00008000);
    vecs[11] = mk(L0, 32'h0,        L0,L1,L0, L0,L0,L0, 16'h0000,16'h0000, L0,L1,L0, 32'h00308000,32'h00008000);
    vecs[12] = mk(L0, 32'h0,        L0,L0,L0, L0,L0,L1, 16'h0000,16'h0040, L0,L1,L0, 32'h00308000,32'h00008000);
    vecs[13] = mk(L1, 32'h01048000, L0,L0,L0, L0,L0,L0, 16'h0000,16'h0000, L0,L1,L0, 32'h00308000,32'h00008000);
    vecs[14] = mk(L0, 32'h0,        L1,L0,L1, L0,L0,L0, 16'h0000,16'h0000, L0,L0,L0, 32'h01048000,32'hFFFC8000);
    vecs[15] = mk(L0, 32'h0,        L0,L0,L0, L0,L1,L0, 16'h0000,16'h0004, L0,L1,L1, 32'h01048000,32'hFFFC8000);
    vecs[16] = mk(L0, 32'h0,        L0,L1,L0, L0,L0,L0, 16'h0000,16'h0000, L0,L1,L1, 32'h01048000,32'hFFFC8000);
    vecs[17] = mk(L0, 32'h0,        L0,L0,L0, L1,L1,L0, 16'h0001,16'h0001, L0,L1,L1, 32'h01048000,32'hFFFC8000);
    vecs[18] = mk(L1, 32'h0007FFFF, L0,L1,L0, L0,L0,L0, 16'h0000,16'h0000, L0,L1,L1, 32'h01048000,32'hFFFC8000);
    vecs[19] = mk(L0, 32'h0,        L0,L0,L0, L1,L0,L0, 16'h0000,16'h0000, L0,L0,L1, 32'h0007FFFF,32'hFFFFFFFF);
    vecs[20] = mk(L0, 32'h0,        L0,L0,L0, L0,L1,L1, 16'h0000,16'h0000, L0,L0,L1, 32'h0007FFFF,32'hFFFFFFFF);

    // reset state
    #12;
    chk("reset R_in", {16'h0, R_in}, 32'h0);
    chk("reset R_out", {16'h0, R_out}, 32'h0);
    chk("reset BA_zero", {31'h0, BA_zero}, 32'h0);
    chk("reset sel_valid", {31'h0, sel_valid}, 32'h0);
    chk("reset sel_error", {31'h0, sel_error}, 32'h0);
    chk("reset ir_q", ir_q, 32'h0);
    chk("reset C_sign_extended", C_sign_extended, 32'h0);
    @(negedge clock);
    clear = 1'b0;

    // table-driven vectors, one per clock cycle
    for (int i = 0; i < 21; i++) begin
      @(posedge clock);
      #1;
      IRin = vecs[i].irin; instruction_in = vecs[i].instr;
      Gra = vecs[i].gra; Grb = vecs[i].grb; Grc = vecs[i].grc;
      Rin = vecs[i].rin; Rout = vecs[i].rout; BAout = vecs[i].baout;
      sb_q.push_back(vecs[i]);
    end
    @(posedge clock);
    #1;
    IRin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    @(negedge clock);
    #1;
    chk("scoreboard drained", sb_q.size(), 32'd0);

    // async clear between edges while Rin active (sel_error is still set)
    @(posedge clock); #1; IRin = 1'b1; instruction_in = 32'h0A9A0000;
    @(posedge clock); #1; IRin = 1'b0; Gra = 1'b1;
    @(posedge clock); #1; Gra = 1'b0; Rin = 1'b1;
    @(negedge clock);
    chk("pre-clear R_in", {16'h0, R_in}, 32'h00000020);
    chk("pre-clear sel_error", {31'h0, sel_error}, 32'h1);
    #2;
    clear = 1'b1;
    #1;
    chk("async clear R_in", {16'h0, R_in}, 32'h0);
    chk("async clear ir_q", ir_q, 32'h0);
    chk("async clear sel_valid", {31'h0, sel_valid}, 32'h0);
    chk("async clear sel_error", {31'h0, sel_error}, 32'h0);
    chk("async clear C_sign_extended", C_sign_extended, 32'h0);
    Rin = 1'b0;
    @(negedge clock);
    clear = 1'b0;

    // 32-register instance: Ra = 31 in bits 26:22
    @(posedge clock); #1; IRin2 = 1'b1; instruction_in2 = 32'h07C00000;
    @(posedge clock); #1; IRin2 = 1'b0; Gra2 = 1'b1;
    @(posedge clock); #1; Gra2 = 1'b0; Rout2 = 1'b1; Rin2 = 1'b1;
    @(negedge clock);
    chk("dut2 R_out", R_out2, 32'h80000000);
    chk("dut2 R_in", R_in2, 32'h80000000);
    chk("dut2 sel_valid", {31'h0, sel_valid2}, 32'h1);
    chk("dut2 sel_error", {31'h0, sel_error2}, 32'h0);
    chk("dut2 BA_zero", {31'h0, BA_zero2}, 32'h0);
    chk("dut2 ir_q", ir_q2, 32'h07C00000);
    chk("dut2 C_sign_extended", C_sign_extended2, 32'h00000000);
    @(posedge clock); #1; Rout2 = 1'b0; Rin2 = 1'b0;
    @(negedge clock);
    chk("dut2 R_out idle", R_out2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/select_encode_reg.md
Name: select_encode_reg

Overview:
- Parametrised, clocked register select/encode unit for the datapath's general-purpose register file.
- Holds its own copy of the instruction register (IR).
- Registers the Ra/Rb/Rc field decode as a one-hot selection with a validity flag.
- Gates the selection with Rin/Rout/BAout to drive per-register enables, with R0 base-address zeroing and a conflict flag.
- Sign-extends the C immediate to the data width; sits between the control unit and the register file / bus mux.

Parameters:
- NUM_REGS, 16, number of general-purpose registers; must equal 2**REG_BITS.
- REG_BITS, 4, width of each register field in the instruction.
- DATA_WIDTH, 32, instruction and bus width.
- RA_MSB, 26, MSB of the Ra field. Rb sits directly below Ra; Rc sits directly below Rb.
- IMM_WIDTH, 19, width of the C immediate, taken from bits IMM_WIDTH-1:0.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- IRin  in  1  load instruction_in into the internal IR.
- instruction_in  in  DATA_WIDTH  instruction from the bus.
- Gra  in  1  select the Ra field.
- Grb  in  1  select the Rb field.
- Grc  in  1  select the Rc field.
- Rin  in  1  register write strobe.
- Rout  in  1  register read strobe.
- BAout  in  1  base-address read strobe.
- R_in  out  NUM_REGS  one-hot register write enables.
- R_out  out  NUM_REGS  one-hot register read enables.
- BA_zero  out  1  bus mux must drive zero (BAout with R0 selected).
- C_sign_extended  out  DATA_WIDTH  sign-extended immediate from the IR.
- sel_valid  out  1  a selection is latched and current.
- sel_error  out  1  sticky: more than one G line was asserted.
- ir_q  out  DATA_WIDTH  current IR contents.

Behaviour:
- Reset (clear high, asynchronous):
  - ir_q = 0, selection register = 0, sel_valid = 0, sel_error = 0.
  - R_in = 0, R_out = 0, BA_zero = 0, C_sign_extended = 0.
- IR load: IRin high at an edge gives ir_q <= instruction_in. Field extraction and C_sign_extended always use ir_q, never instruction_in.
- Field extraction from ir_q:
  - Ra = ir_q[RA_MSB : RA_MSB-REG_BITS+1]
  - Rb = the next REG_BITS bits below Ra.
  - Rc = the next REG_BITS bits below Rb.
- Selection register update at each edge:
  - IRin high: selection cleared, sel_valid <= 0. All G lines are ignored this cycle, so the decode is not stale.
  - Otherwise, any G high: selection <= one-hot of the chosen field (priority Gra > Grb > Grc), sel_valid <= 1.
  - Otherwise (no G high): selection and sel_valid hold. The control unit may pulse G for one cycle and then use Rin/Rout for several cycles.
- Conflict: two or more G lines high in a non-IRin cycle sets sel_error. It is sticky until clear. The priority selection is still taken.
- Latency: a G line asserted in cycle N gives enables usable from cycle N+1. The control unit asserts G at least one cycle before Rin/Rout/BAout.
- Output gating (combinational from registered state):
  - R_in[i] = sel[i] & sel_valid & Rin.
  - R_out[i] = sel[i] & sel_valid & (Rout | (BAout & i!=0)).
  - BA_zero = sel[0] & sel_valid & BAout & ~Rout.
- Rout and BAout together on R0: Rout wins, so R_out[0] = 1 and BA_zero = 0.
- Rin and Rout may be asserted together; both enables assert for the same register.
- At most one bit of R_in and at most one bit of R_out is high in any cycle.
- C_sign_extended = ir_q[IMM_WIDTH-1:0] sign-extended to DATA_WIDTH with bit IMM_WIDTH-1 replicated. It updates one cycle after IRin.
- No enable is ever driven from an unselected state: sel_valid = 0 forces R_in, R_out and BA_zero to 0.

Test Plan:
1. Reset, then IRin with instruction_in = 0x0A9A0000 (Ra=5, Rb=3, Rc=4) -> next cycle ir_q = 0x0A9A0000 and C_sign_extended = 0x00020000. Then Grb one cycle, then Rout -> R_out = 0x0008, R_in = 0.
2. Same IR, Gra pulsed, then Rin held for 3 cycles with no G -> R_in = 0x0020 for all 3 cycles. sel_valid stays 1.
3. IR with Ra=0, Gra, then BAout -> R_out = 0, BA_zero = 1. BAout+Rout -> R_out = 0x0001, BA_zero = 0.
4. Gra and Grc in the same cycle (Ra=2, Rc=9) -> selection = R2, sel_error = 1 and stays 1 through later cycles until clear.
5. IRin and Grb in the same cycle after a valid selection -> sel_valid = 0 and Rin gives R_in = 0. Immediate field 0x7FFFF gives C_sign_extended = 0xFFFFFFFF.
6. clear asserted mid-operation, asynchronously between edges, while Rin active -> R_in, ir_q, sel_valid and sel_error all 0 immediately. Then repeat with NUM_REGS=32, REG_BITS=5, RA_MSB=26 -> Ra=31 selects R_out[31].
